// File: rtl/fifo_lane_rdchk.sv
// Read-side checker for one lane FIFO: pops words, tracks the incrementing
// counter pattern and accumulates ECC / mismatch statistics for lane status.
module fifo_lane_rdchk #(
  parameter int N        = 32,
  parameter int CW       = 16,
  parameter int WARN_THR = 8,
  parameter int RELOCK   = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic          fifo_empty_i,
  output logic          fifo_rd_o,
  input  logic [N-1:0]  fifo_data_i,
  input  logic          fifo_sbiterr_i,
  input  logic          fifo_dbiterr_i,
  output logic          lock_o,
  output logic [CW-1:0] sbit_cnt_o,
  output logic [CW-1:0] dbit_cnt_o,
  output logic [CW-1:0] mism_cnt_o,
  output logic          err_o,
  output logic          pg_warn_o
);

  localparam int RW = $clog2(RELOCK + 1);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam logic [CW-1:0] WTHR = CW'(WARN_THR);
  localparam logic [RW-1:0] RLK  = RW'(RELOCK);

  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_e;

  state_e        state_q, state_d;
  logic          vld_q;
  logic [N-1:0]  exp_q, exp_d;
  logic [RW-1:0] run_q, run_d;
  logic          lock_q, lock_d;
  logic [CW-1:0] sbit_q, sbit_d, dbit_q, dbit_d, mism_q, mism_d;
  logic          err_q, err_d;
  logic          warn_q;
  logic          take, inc_sb, inc_db, inc_mm;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CMAX) ? c : c + CW'(1);
  endfunction

  assign fifo_rd_o = en_i & ~fifo_empty_i & (state_q != IDLE);
  // A word that lands while the checker is being disabled is dropped unseen.
  assign take      = vld_q & en_i;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    lock_d  = lock_q;
    inc_sb  = 1'b0;
    inc_db  = 1'b0;
    inc_mm  = 1'b0;
    case (state_q)
      IDLE: if (en_i) state_d = SYNC;
      SYNC: begin
        if (take) begin
          if (fifo_dbiterr_i) inc_db = 1'b1;
          else begin
            exp_d   = fifo_data_i + N'(1);
            lock_d  = 1'b1;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (take) begin
          if (fifo_dbiterr_i) begin
            inc_db = 1'b1;
            exp_d  = exp_q + N'(1);
          end else if (fifo_data_i == exp_q) begin
            exp_d = exp_q + N'(1);
            run_d = '0;
          end else begin
            inc_mm = 1'b1;
            exp_d  = fifo_data_i + N'(1);
            run_d  = run_q + RW'(1);
          end
          if (run_d == RLK) begin
            lock_d  = 1'b0;
            run_d   = '0;
            state_d = SYNC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (take && fifo_sbiterr_i) inc_sb = 1'b1;
    if (!en_i) begin
      state_d = IDLE;
      lock_d  = 1'b0;
    end

    sbit_d = inc_sb ? sat_inc(sbit_q) : sbit_q;
    dbit_d = inc_db ? sat_inc(dbit_q) : dbit_q;
    mism_d = inc_mm ? sat_inc(mism_q) : mism_q;
    err_d  = err_q | inc_db | inc_mm;
    // Clear beats any same-cycle event.
    if (clr_i) begin
      sbit_d = '0;
      dbit_d = '0;
      mism_d = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      exp_q   <= '0;
      run_q   <= '0;
      lock_q  <= 1'b0;
      sbit_q  <= '0;
      dbit_q  <= '0;
      mism_q  <= '0;
      err_q   <= 1'b0;
      warn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= fifo_rd_o;
      exp_q   <= exp_d;
      run_q   <= run_d;
      lock_q  <= lock_d;
      sbit_q  <= sbit_d;
      dbit_q  <= dbit_d;
      mism_q  <= mism_d;
      err_q   <= err_d;
      warn_q  <= (sbit_d >= WTHR);
    end
  end

  assign lock_o     = lock_q;
  assign sbit_cnt_o = sbit_q;
  assign dbit_cnt_o = dbit_q;
  assign mism_cnt_o = mism_q;
  assign err_o      = err_q;
  assign pg_warn_o  = warn_q;

endmodule

// File: tb/tb_fifo_lane_rdchk.sv
// Directed bench for fifo_lane_rdchk: a non-FWFT FIFO model feeds hand-built
// word streams and each status output is compared with hand-derived values.
module tb_fifo_lane_rdchk;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0;
  logic        fifo_empty, fifo_rd;
  logic [31:0] fifo_data = '0;
  logic        sb = 1'b0, db = 1'b0;
  logic        lock, err, warn;
  logic [15:0] sbit_cnt, dbit_cnt, mism_cnt;

  int nchk = 0, nerr = 0;
  logic [33:0] fmem [0:4095];
  int wp = 0, rp = 0, nrd = 0, n0;

  fifo_lane_rdchk dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr),
    .fifo_empty_i(fifo_empty), .fifo_rd_o(fifo_rd), .fifo_data_i(fifo_data),
    .fifo_sbiterr_i(sb), .fifo_dbiterr_i(db), .lock_o(lock),
    .sbit_cnt_o(sbit_cnt), .dbit_cnt_o(dbit_cnt), .mism_cnt_o(mism_cnt),
    .err_o(err), .pg_warn_o(warn)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (fifo_rd) begin
      {db, sb, fifo_data} <= fmem[rp[11:0]];
      rp  <= rp + 1;
      nrd <= nrd + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic s = 1'b0, input logic b = 1'b0);
    fmem[wp[11:0]] = {b, s, d};
    wp++;
  endtask

  task automatic push_seq(input logic [31:0] start, input int cnt);
    for (int i = 0; i < cnt; i++) push(start + 32'(i));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    while (wp != rp && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_bound", k < 3000, 1);
    tick(3);
  endtask

  initial begin
    int k;
    #1;
    chk("rst_rd", fifo_rd, 0);
    chk("rst_lock", lock, 0);
    chk("rst_sbit", sbit_cnt, 0);
    chk("rst_dbit", dbit_cnt, 0);
    chk("rst_mism", mism_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_warn", warn, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 256-word clean stream; lock appears two cycles after the first read
    push_seq(32'h5, 256);
    en = 1'b1;
    k = 0;
    while (!fifo_rd && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("first_rd_bound", k < 10, 1);
    tick(1);
    chk("lock_early", lock, 0);
    tick(1);
    chk("lock_2cyc", lock, 1);
    drain();
    chk("reads_256", nrd, 256);
    chk("clean_mism", mism_cnt, 0);
    chk("clean_sbit", sbit_cnt, 0);
    chk("clean_dbit", dbit_cnt, 0);
    chk("clean_err", err, 0);

    // disable, re-enable and lock across the 2^N-1 -> 0 wrap
    en = 1'b0;
    tick(1);
    chk("dis_lock", lock, 0);
    en = 1'b1;
    push(32'hFFFF_FFFE); push(32'hFFFF_FFFF); push(32'h0); push(32'h1);
    drain();
    chk("wrap_mism", mism_cnt, 0);
    chk("wrap_lock", lock, 1);
    chk("wrap_err", err, 0);

    // dbiterr word with garbage data is skipped, sequence continues
    push_seq(32'h2, 14);
    push(32'hDEAD, 1'b0, 1'b1);
    push_seq(32'h11, 3);
    drain();
    chk("db_dbit", dbit_cnt, 1);
    chk("db_err", err, 1);
    chk("db_mism", mism_cnt, 0);
    chk("db_lock", lock, 1);

    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_dbit", dbit_cnt, 0);
    chk("clr_err", err, 0);

    // corrected errors: warning threshold crossed at exactly 8
    for (int i = 0; i < 7; i++) push(32'h14 + 32'(i), 1'b1, 1'b0);
    drain();
    chk("sb7_cnt", sbit_cnt, 7);
    chk("sb7_warn", warn, 0);
    push(32'h1B, 1'b1, 1'b0);
    drain();
    chk("sb8_cnt", sbit_cnt, 8);
    chk("sb8_warn", warn, 1);
    chk("sb8_err", err, 0);
    chk("sb8_mism", mism_cnt, 0);

    // 0x99 in place of 0x20: resync to 0x9A, 0x21 mismatches, 0x22 realigns
    push_seq(32'h1C, 4);
    push(32'h99);
    push_seq(32'h21, 3);
    drain();
    chk("mm_cnt2", mism_cnt, 2);
    chk("mm_lock", lock, 1);
    push(32'h100); push(32'h200); push(32'h300);
    drain();
    chk("mm_run3_cnt", mism_cnt, 5);
    chk("mm_run3_lock", lock, 1);
    push(32'h400);
    drain();
    chk("mm_run4_cnt", mism_cnt, 6);
    chk("mm_run4_lock", lock, 0);
    push(32'h500); push(32'h501);
    drain();
    chk("relock", lock, 1);
    chk("relock_mism", mism_cnt, 6);
    chk("relock_err", err, 1);

    // clear on the same cycle as a mismatch: clear wins
    push(32'h777);
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clrhit_mism", mism_cnt, 0);
    chk("clrhit_sbit", sbit_cnt, 0);
    chk("clrhit_err", err, 0);
    chk("clrhit_warn", warn, 0);
    chk("clrhit_lock", lock, 1);

    // drop enable with a mismatching word in flight
    n0 = nrd;
    push(32'h1234); push(32'h1235);
    tick(1);
    en = 1'b0;
    #1;
    chk("endrop_rd_now", fifo_rd, 0);
    tick(1);
    chk("endrop_rd", fifo_rd, 0);
    chk("endrop_mism", mism_cnt, 0);
    chk("endrop_err", err, 0);
    chk("endrop_lock", lock, 0);
    chk("endrop_reads", nrd, n0 + 1);
    en = 1'b1;
    drain();
    chk("reen_lock", lock, 1);
    chk("reen_mism", mism_cnt, 0);

    // asynchronous reset mid-stream
    push(32'h1236, 1'b1, 1'b0);
    push(32'h1237, 1'b0, 1'b1);
    push_seq(32'h1238, 20);
    tick(4);
    chk("pre_rst_sbit", sbit_cnt, 1);
    chk("pre_rst_dbit", dbit_cnt, 1);
    chk("pre_rst_err", err, 1);
    chk("pre_rst_lock", lock, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lock", lock, 0);
    chk("arst_rd", fifo_rd, 0);
    chk("arst_sbit", sbit_cnt, 0);
    chk("arst_dbit", dbit_cnt, 0);
    chk("arst_mism", mism_cnt, 0);
    chk("arst_err", err, 0);
    chk("arst_warn", warn, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
